// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and its frame FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int ENTRY_W      = 11;
  localparam int ENT_DATA_LSB = 0;
  localparam int ENT_DATA_MSB = 7;
  localparam int ENT_PERR     = 8;
  localparam int ENT_FERR     = 9;
  localparam int ENT_BRK      = 10;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// Synchronous FIFO; full/empty come from pointers carrying one extra wrap bit.
module uart_rx_fifo_buf #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with parity/framing/break capture feeding a frame FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sdi,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          bit8,
  input  logic                          pen,
  input  logic                          ohel,
  input  logic                          read,
  output logic [7:0]                    rx_data,
  output logic                          rxrdy,
  output logic                          perr,
  output logic                          ferr,
  output logic                          brk,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic             s1_q, s2_q, s3_q, fall;
  logic [DIV_W-1:0] tick_cnt_q, reload;
  logic             tick;
  rx_state_e        state_q, state_d;
  logic [CW-1:0]    os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             bit8_q, bit8_d, pen_q, pen_d, ohel_q, ohel_d;
  logic             push, pop, full, empty, overflow;
  logic             perr_f, ferr_f, brk_f;
  logic [ENTRY_W-1:0] entry, head;

  assign fall   = s3_q & ~s2_q;
  assign reload = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick   = (tick_cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      ovf        <= 1'b0;
    end else begin
      s1_q       <= sdi;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      tick_cnt_q <= tick ? reload : tick_cnt_q - DIV_W'(1);
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      if (overflow)  ovf <= 1'b1;
      else if (read) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    par_q  <= par_d;
    bit8_q <= bit8_d;
    pen_q  <= pen_d;
    ohel_q <= ohel_d;
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    bit8_d    = bit8_q;
    pen_d     = pen_q;
    ohel_d    = ohel_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          os_cnt_d  = '0;
          bit_idx_d = '0;
          data_d    = '0;
          par_d     = 1'b0;
          bit8_d    = bit8;
          pen_d     = pen;
          ohel_d    = ohel;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == HALF_M1) begin
            os_cnt_d = '0;
            state_d  = s2_q ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt_q == FULL_M1) begin
            os_cnt_d          = '0;
            data_d[bit_idx_q] = s2_q;
            if (bit_idx_q == (bit8_q ? 3'd7 : 3'd6)) state_d = pen_q ? PARITY : STOP;
            else                                      bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            os_cnt_d = os_cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (os_cnt_q == FULL_M1) begin
            os_cnt_d = '0;
            par_d    = s2_q;
            state_d  = STOP;
          end else begin
            os_cnt_d = os_cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_cnt_q == FULL_M1) begin
            os_cnt_d = '0;
            push     = 1'b1;
            state_d  = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are evaluated on the stop-sample cycle, where s2_q is the stop bit.
  assign perr_f = pen_q & (^data_q ^ par_q ^ (ohel_q == PAR_ODD));
  assign ferr_f = ~s2_q;
  assign brk_f  = (data_q == 8'h00) & ~(pen_q & par_q) & ~s2_q;
  assign entry  = {brk_f, ferr_f, perr_f, data_q};

  assign pop      = read & ~empty;
  assign overflow = push & full & ~pop;

  uart_rx_fifo_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign rxrdy   = ~empty;
  assign rx_data = empty ? 8'h00 : head[ENT_DATA_MSB:ENT_DATA_LSB];
  assign perr    = ~empty & head[ENT_PERR];
  assign ferr    = ~empty & head[ENT_FERR];
  assign brk     = ~empty & head[ENT_BRK];

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the emulated-PicoBlaze I/O subsystem. It combines the following in one block:
- start-bit detection with an oversampling bit-timing FSM;
- 7/8-bit data with optional odd/even parity;
- per-frame error capture, including break detection;
- a FIFO of received frames.

It replaces the fixed single-buffer receive path and presents the head frame plus sticky status to the processor read port.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; even, >= 4.
FIFO_DEPTH, 8, frames buffered; power of 2, >= 2.
DIV_W, 16, width of the baud divisor.

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
sdi  in  1  serial data in, asynchronous, idle high
baud_div  in  DIV_W  clocks per oversample tick; 0 treated as 1
bit8  in  1  1 = 8 data bits, 0 = 7
pen  in  1  parity enable
ohel  in  1  parity sense: 1 = odd, 0 = even
read  in  1  single-cycle pop/acknowledge strobe
rx_data  out  8  head frame data; bit 7 = 0 in 7-bit frames
rxrdy  out  1  FIFO non-empty
perr  out  1  head frame parity error
ferr  out  1  head frame framing error (stop bit sampled 0)
brk  out  1  head frame is a break
ovf  out  1  sticky overflow
fifo_count  out  $clog2(FIFO_DEPTH)+1  frames held

Behaviour:
- Reset values: all outputs 0, FSM IDLE, FIFO empty, tick counter 0. Synchroniser flops reset to 1.
- Synchroniser: sdi passes through 2 flops; the edge detector uses a third registered copy.
- Tick generator: free-running down-counter reloads baud_div-1 and pulses tick for one clk at 0. The bit-timing counter advances only on tick.
- Config latch: bit8, pen and ohel are latched on the IDLE->START transition. Changing them mid-frame has no effect on the frame in progress.
- FSM IDLE: a falling edge (previous 1, current 0) -> START, with sample counter cleared.
- FSM START: at tick count OVERSAMPLE/2-1, line still 0 -> DATA; line 1 -> IDLE (glitch rejected, nothing pushed).
- FSM DATA: one sample every OVERSAMPLE ticks, taken mid-bit, LSB first. After 7 or 8 bits -> PARITY if pen, else STOP.
- FSM PARITY: one sample -> STOP.
- FSM STOP: one sample. On the sample cycle the frame {brk, ferr, perr, data} is pushed, then -> IDLE.
- Re-arm: IDLE needs a new falling edge, so a line held low after a framing error cannot retrigger.
- perr = pen & (XOR of data bits ^ parity bit ^ ohel).
- ferr = stop sample == 0.
- brk = all data bits 0, parity bit 0 (when pen), and stop bit 0.
- Latency: rxrdy and the head outputs update exactly 1 clk after the stop-sample cycle. With baud_div=1, the stop sample falls 8+16*(N-1) clk after the synchronised falling edge, where N = frame bits including start.
- FIFO: rx_data, perr, ferr and brk always show the head entry. They are don't-care when rxrdy=0; the implementation drives 0.
- read while rxrdy=1: pops the head.
- read while empty: no pop.
- Any read clears ovf; a simultaneous overflow sets ovf again, and set wins.
- Push while full with no pop: frame discarded, ovf <= 1, FIFO contents unchanged.
- Push and pop in the same cycle while full: both occur, count unchanged, no ovf.
- Push and read in the same cycle while empty: push occurs, read ignored, count = 1.
- Pointers wrap modulo FIFO_DEPTH; fifo_count saturates at FIFO_DEPTH.
- Reset asserted mid-frame: partial frame discarded, FIFO flushed, ovf cleared, FSM IDLE.

Decomposition:
- Package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, PARITY, STOP);
  - frame-entry width constant (11 = 8 data + 3 flags);
  - entry field index constants;
  - parity-sense encodings.
- Sub-module uart_rx_fifo_buf: generic synchronous FIFO (width, depth parameters) with push, pop, full, empty and count. Full/empty are derived from extra-bit pointers.
- The FSM, tick generator, synchroniser and error logic stay in uart_rx_fifo.

Test Plan:
1. baud_div=1, 8N1, byte 0xA5 -> rxrdy=1 at 8+16*9+1 clk after the synchronised edge; rx_data=0xA5; perr=ferr=brk=0; fifo_count=1; read -> rxrdy=0.
2. 8-bit, pen=1, ohel=0, 0x37 with parity bit 1 -> perr=0. Same byte with parity bit 0 -> perr=1. Repeat with ohel=1 -> results inverted.
3. 7-bit, no parity, data 0x7F, stop bit driven 0 -> rx_data=0x7F, ferr=1, brk=0. A following valid frame 0x12 is received correctly, without a false start.
4. sdi pulsed low for 5 clk (baud_div=1) -> no push, FSM back in IDLE, fifo_count=0. Then a valid frame 0x3C -> rx_data=0x3C.
5. FIFO_DEPTH+1 frames 0x01..0x09 with no read -> fifo_count=8, ovf=1, head=0x01. Eight reads return 0x01..0x08; the first read clears ovf. Push and pop on the same cycle while full -> no ovf.
6. sdi held low for 12 bit times with pen=1 -> one frame with rx_data=0x00, brk=1, ferr=1. Reset asserted mid-way through a second frame -> all outputs 0, and the next frame 0x55 is received cleanly.
